// File: rtl/mempipe_arb_n.sv
// mm0 arbiter of the L1 memory pipeline: picks one of NUM_REQ requesters per cycle (fixed priority
// or round robin) and registers the winner into mm1. MEMPIPE_ARB_STARVE_EN adds starvation override.
module mempipe_arb_n #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned PKT_W      = 128,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_mm0_i,
    input  logic [NUM_REQ*PKT_W-1:0]   req_pkt_mm0_i,
    output logic [NUM_REQ-1:0]         gnt_mm0_o,
    input  logic                       pipe_stall_mm0_i,
    input  logic                       flush_i,
    output logic                       valid_mm1_o,
    output logic [PKT_W-1:0]           req_pkt_mm1_o,
    output logic [$clog2(NUM_REQ)-1:0] req_id_mm1_o,
    output logic                       starve_any_o
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned SumW = IdW + 1;

    if (NUM_REQ < 2 || STARVE_MAX < 1) begin : g_bad_params
        $error("mempipe_arb_n: NUM_REQ must be >= 2 and STARVE_MAX >= 1");
    end

    logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                   valid_q, valid_d;
    logic [PKT_W-1:0]       pkt_q, pkt_d;
    logic [IdW-1:0]         id_q, id_d;

    logic                   gnt_en;
    logic [NUM_REQ-1:0]     starve_req;
    logic [IdW-1:0]         fp_idx;
    logic [IdW-1:0]         rr_idx;
    logic [IdW-1:0]         rr_off;
    logic [SumW-1:0]        rr_sum;
    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [IdW-1:0]         ov_idx;
    logic                   ov_found;
    logic [IdW-1:0]         win_idx;
    logic [PKT_W-1:0]       win_pkt;

    // Reset is folded in so no grant can leak while the flops are held in reset.
    assign gnt_en = ~rst_i & ~pipe_stall_mm0_i & ~flush_i & (|req_mm0_i);

    always_comb begin
        fp_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_mm0_i[i]) begin
                fp_idx = IdW'(i);
            end
        end
    end

    // Rotate requests so bit 0 is rr_ptr, find the nearest one, then rotate the offset back.
    always_comb begin
        req_dbl = {req_mm0_i, req_mm0_i} >> rr_ptr_q;
        rr_off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_dbl[i]) begin
                rr_off = IdW'(i);
            end
        end
        rr_sum = SumW'(rr_ptr_q) + SumW'(rr_off);
        if (rr_sum >= SumW'(NUM_REQ)) begin
            rr_idx = IdW'(rr_sum - SumW'(NUM_REQ));
        end else begin
            rr_idx = IdW'(rr_sum);
        end
    end

    always_comb begin
        ov_idx   = '0;
        ov_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starve_req[i]) begin
                ov_idx   = IdW'(i);
                ov_found = 1'b1;
            end
        end
    end

    always_comb begin
        if (ov_found) begin
            win_idx = ov_idx;
        end else if (ARB_MODE == 1) begin
            win_idx = rr_idx;
        end else begin
            win_idx = fp_idx;
        end
    end

    always_comb begin
        gnt_mm0_o = '0;
        if (gnt_en) begin
            gnt_mm0_o = NUM_REQ'(1) << win_idx;
        end
    end

    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdW'(i)) begin
                win_pkt = req_pkt_mm0_i[i*PKT_W +: PKT_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (ARB_MODE == 1 && gnt_en) begin
            rr_ptr_d = (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + IdW'(1);
        end
    end

    always_comb begin
        valid_d = gnt_en;
        pkt_d   = pkt_q;
        id_d    = id_q;
        if (gnt_en) begin
            pkt_d = win_pkt;
            id_d  = win_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            pkt_q    <= '0;
            id_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            pkt_q    <= pkt_d;
            id_q     <= id_d;
        end
    end

    assign valid_mm1_o   = valid_q;
    assign req_pkt_mm1_o = pkt_q;
    assign req_id_mm1_o  = id_q;

`ifdef MEMPIPE_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0]    cnt_q [NUM_REQ];
    logic [CntW-1:0]    cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] starve_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_hit[i] = (cnt_q[i] == CntMax);
            starve_req[i] = starve_hit[i] & req_mm0_i[i];
        end
    end

    // Stall cycles freeze the count; flush and a dropped request restart it.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_mm0_o[i] || !req_mm0_i[i] || flush_i) begin
                cnt_d[i] = '0;
            end else if (pipe_stall_mm0_i || cnt_q[i] == CntMax) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign starve_any_o = |starve_hit;
`else
    assign starve_req   = '0;
    assign starve_any_o = 1'b0;
`endif

    gnt_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_mm0_o));
    gnt_on_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                   (gnt_mm0_o & ~req_mm0_i) == '0);

endmodule

// File: tb/tb_mempipe_arb_n.sv
// Bench for mempipe_arb_n: a fixed-priority (STARVE_MAX=3) and a round-robin instance share stimulus;
// grants come from a vector table, mm1 contents from a scoreboard queue filled as vectors are driven.
module tb_mempipe_arb_n;

    localparam int N  = 3;
    localparam int PW = 16;
`ifdef MEMPIPE_ARB_STARVE_EN
    localparam bit StarveEn = 1'b1;
`else
    localparam bit StarveEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*PW-1:0] pkt;
    logic            stall;
    logic            flush;

    logic [N-1:0]  gnt_fp, gnt_rr;
    logic          valid_fp, valid_rr;
    logic [PW-1:0] pkt_fp, pkt_rr;
    logic [1:0]    id_fp, id_rr;
    logic          starve_fp, starve_rr;

    always #5 clk = ~clk;

    mempipe_arb_n #(.NUM_REQ(N), .PKT_W(PW), .ARB_MODE(0), .STARVE_MAX(3)) u_fp (
        .clk_i(clk), .rst_i(rst), .req_mm0_i(req), .req_pkt_mm0_i(pkt), .gnt_mm0_o(gnt_fp),
        .pipe_stall_mm0_i(stall), .flush_i(flush), .valid_mm1_o(valid_fp),
        .req_pkt_mm1_o(pkt_fp), .req_id_mm1_o(id_fp), .starve_any_o(starve_fp)
    );

    mempipe_arb_n #(.NUM_REQ(N), .PKT_W(PW), .ARB_MODE(1), .STARVE_MAX(15)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_mm0_i(req), .req_pkt_mm0_i(pkt), .gnt_mm0_o(gnt_rr),
        .pipe_stall_mm0_i(stall), .flush_i(flush), .valid_mm1_o(valid_rr),
        .req_pkt_mm1_o(pkt_rr), .req_id_mm1_o(id_rr), .starve_any_o(starve_rr)
    );

    typedef struct {
        logic [N-1:0] req;
        logic         stall;
        logic         flush;
        logic [N-1:0] gnt_fp;
        logic [N-1:0] gnt_rr;
        logic         starve_fp;
    } vec_t;

    typedef struct {
        logic          valid;
        logic [1:0]    id;
        logic [PW-1:0] pkt;
    } mm1_t;

    vec_t vecs[$];
    mm1_t sb_fp[$];
    mm1_t sb_rr[$];
    mm1_t last_fp, last_rr;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic [N-1:0] r, logic s, logic f, logic [N-1:0] gf,
                                logic [N-1:0] gr, logic sf);
        vec_t v;
        v.req = r; v.stall = s; v.flush = f; v.gnt_fp = gf; v.gnt_rr = gr; v.starve_fp = sf;
        return v;
    endfunction

    function automatic logic [PW-1:0] pkt_of(int k, int i);
        return PW'((i + 1) * 4096 + k);
    endfunction

    function automatic mm1_t predict(mm1_t prev, logic [N-1:0] g, int k);
        mm1_t r = prev;
        r.valid = (g != '0);
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                r.id  = 2'(i);
                r.pkt = pkt_of(k, i);
            end
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [N-1:0] r, logic s, logic f, int k);
        req = r; stall = s; flush = f;
        for (int i = 0; i < N; i++) pkt[i*PW +: PW] = pkt_of(k, i);
    endtask

    task automatic check_mm1(string tag);
        mm1_t e;
        if (sb_fp.size() == 0 || sb_rr.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_fp.pop_front();
            chk({tag, " fp valid"}, 32'(valid_fp), 32'(e.valid));
            chk({tag, " fp id"}, 32'(id_fp), 32'(e.id));
            chk({tag, " fp pkt"}, 32'(pkt_fp), 32'(e.pkt));
            e = sb_rr.pop_front();
            chk({tag, " rr valid"}, 32'(valid_rr), 32'(e.valid));
            chk({tag, " rr id"}, 32'(id_rr), 32'(e.id));
            chk({tag, " rr pkt"}, 32'(pkt_rr), 32'(e.pkt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        // Back-to-back 111 (starvation kicks in on fp when enabled), flush, stall, 011, flush pair
        vecs.push_back(mk(3'b111, 0, 0, 3'b001, 3'b001, 1'b0));
        vecs.push_back(mk(3'b111, 0, 0, 3'b001, 3'b010, 1'b0));
        vecs.push_back(mk(3'b111, 0, 0, 3'b001, 3'b100, 1'b0));
        vecs.push_back(mk(3'b111, 0, 0, StarveEn ? 3'b010 : 3'b001, 3'b001, StarveEn));
        vecs.push_back(mk(3'b111, 0, 0, StarveEn ? 3'b100 : 3'b001, 3'b010, StarveEn));
        vecs.push_back(mk(3'b111, 0, 0, 3'b001, 3'b100, 1'b0));
        vecs.push_back(mk(3'b111, 0, 1, 3'b000, 3'b000, 1'b0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(3'b010, 1, 0, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mk(3'b010, 0, 0, 3'b010, 3'b010, 1'b0));
        vecs.push_back(mk(3'b011, 0, 0, 3'b001, 3'b001, 1'b0));
        vecs.push_back(mk(3'b011, 0, 0, 3'b001, 3'b010, 1'b0));
        vecs.push_back(mk(3'b011, 0, 0, 3'b001, 3'b001, 1'b0));
        vecs.push_back(mk(3'b011, 0, 0, StarveEn ? 3'b010 : 3'b001, 3'b010, StarveEn));
        vecs.push_back(mk(3'b011, 0, 0, 3'b001, 3'b001, 1'b0));
        vecs.push_back(mk(3'b011, 0, 1, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mk(3'b111, 1, 1, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mk(3'b111, 0, 0, 3'b001, 3'b010, 1'b0));
        vecs.push_back(mk(3'b100, 0, 0, 3'b100, 3'b100, 1'b0));
        vecs.push_back(mk(3'b000, 0, 0, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mk(3'b110, 0, 0, 3'b010, 3'b010, 1'b0));
        vecs.push_back(mk(3'b101, 0, 0, 3'b001, 3'b100, 1'b0));

        // Reset state, with requests present to show grants are held off
        rst = 1'b1;
        drive(3'b111, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset gnt fp", 32'(gnt_fp), 32'd0);
        chk("reset gnt rr", 32'(gnt_rr), 32'd0);
        chk("reset valid fp", 32'(valid_fp), 32'd0);
        chk("reset pkt fp", 32'(pkt_fp), 32'd0);
        chk("reset id rr", 32'(id_rr), 32'd0);
        chk("reset starve fp", 32'(starve_fp), 32'd0);
        @(negedge clk);
        drive(3'b000, 0, 0, 0);
        rst = 1'b0;
        last_fp = '{valid: 1'b0, id: 2'd0, pkt: '0};
        last_rr = last_fp;
        sb_fp.push_back(last_fp);
        sb_rr.push_back(last_rr);

        for (int k = 0; k < vecs.size(); k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            @(negedge clk);
            drive(vecs[k].req, vecs[k].stall, vecs[k].flush, k + 1);
            #1;
            check_mm1(tag);
            chk({tag, " gnt fp"}, 32'(gnt_fp), 32'(vecs[k].gnt_fp));
            chk({tag, " gnt rr"}, 32'(gnt_rr), 32'(vecs[k].gnt_rr));
            chk({tag, " starve fp"}, 32'(starve_fp), 32'(vecs[k].starve_fp));
            chk({tag, " starve rr"}, 32'(starve_rr), 32'd0);
            last_fp = predict(last_fp, vecs[k].gnt_fp, k + 1);
            last_rr = predict(last_rr, vecs[k].gnt_rr, k + 1);
            sb_fp.push_back(last_fp);
            sb_rr.push_back(last_rr);
        end
        @(negedge clk);
        drive(3'b000, 0, 0, 99);
        #1;
        check_mm1("drain");

        // Reset in the middle of traffic with valid_mm1 high and rr_ptr advanced
        @(negedge clk);
        drive(3'b111, 0, 0, 100);
        #1;
        chk("pre-reset gnt fp", 32'(gnt_fp), 32'b001);
        chk("pre-reset gnt rr", 32'(gnt_rr), 32'b001);
        @(negedge clk);
        #1;
        chk("pre-reset valid rr", 32'(valid_rr), 32'd1);
        chk("pre-reset gnt rr advanced", 32'(gnt_rr), 32'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("mid reset valid fp", 32'(valid_fp), 32'd0);
        chk("mid reset valid rr", 32'(valid_rr), 32'd0);
        chk("mid reset gnt fp", 32'(gnt_fp), 32'd0);
        chk("mid reset gnt rr", 32'(gnt_rr), 32'd0);
        chk("mid reset pkt rr", 32'(pkt_rr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post reset gnt rr", 32'(gnt_rr), 32'b001);
        chk("post reset gnt fp", 32'(gnt_fp), 32'b001);
        @(negedge clk);
        #1;
        chk("post reset valid rr", 32'(valid_rr), 32'd1);
        chk("post reset id rr", 32'(id_rr), 32'd0);
        chk("post reset pkt rr", 32'(pkt_rr), 32'(pkt_of(100, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
